mem_bus_if: RTL and testbench
=============================

# mem_bus_if

Memory bus interface between the shared 32-bit `databus` of the multi-cycle RV core and the synchronous block RAM. It holds a memory address register (MAR) and a memory data register (MDR), each loaded from the bus. On a read or write request from the control unit it runs a small FSM that sequences the RAM's enable, write and output-register strobes, and reports completion with a one-cycle `done`. It also drives MDR back onto the bus when the control unit requests it, replacing the direct bus-to-RAM hookup in the core top.

## Interface
- `ADDR_W`, default 10: RAM word-address width; the RAM depth is 2^ADDR_W words.
- `DATA_W`, default 32: bus and RAM data width.
- `RD_LAT`, default 2: RAM read latency in cycles, from the address being registered to the output register being valid. Must be ≥ 1.

- `clk` input 1: the single clock; every register updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `bus_in` input DATA_W: current value on `databus`.
- `mar_en` input 1: load MAR from `bus_in`.
- `mdr_en` input 1: load MDR from `bus_in` (write data).
- `rd_req` input 1: start a read at MAR.
- `wr_req` input 1: start a write of MDR to MAR.
- `mdr_bus_en` input 1: request that MDR be driven onto the bus.
- `bus_out` output DATA_W: MDR value.
- `bus_oe` output 1: `bus_out` is valid to drive onto `databus`.
- `busy` output 1: a transaction is in progress.
- `done` output 1: one-cycle completion pulse.
- `misalign` output 1: sticky error flag.
- `ram_addr` output ADDR_W: word address, equal to MAR[ADDR_W+1:2].
- `ram_din` output DATA_W: equal to MDR.
- `ram_en` output 1: RAM enable.
- `ram_we` output 1: RAM write enable.
- `ram_regce` output 1: RAM output-register clock enable.
- `ram_dout` input DATA_W: RAM read data.

## Operation
- **States:** IDLE, RD, CAP, WR, DONE.
- **IDLE:**
  - `mar_en` and `mdr_en` load their registers. Both may be asserted in the same cycle.
  - `rd_req` alone moves to RD and clears the latency counter.
  - `wr_req` alone moves to WR.
  - `rd_req` and `wr_req` together: no transaction starts, the FSM stays in IDLE, and `misalign` is set.
  - A request when MAR[1:0] ≠ 0: no transaction starts, and `misalign` is set.
- **RD:**
  - The counter counts 0..RD_LAT-1.
  - `ram_en` = 1 while the count is 0.
  - `ram_regce` = 1 while the count is RD_LAT-1.
  - When the count reaches RD_LAT-1, the next state is CAP.
- **CAP:** MDR is loaded from `ram_dout`; the next state is DONE.
- **WR:** `ram_en` = 1 and `ram_we` = 1 for exactly one cycle; the next state is DONE.
- **DONE:** `done` = 1 for one cycle; the next state is IDLE.
- **Busy and ignored inputs:**
  - `busy` = 1 in RD, CAP and WR.
  - `rd_req`, `wr_req`, `mar_en` and `mdr_en` are ignored in every state except IDLE. A request made in DONE is also ignored.
- **Bus drive:** `bus_oe` = `mdr_bus_en` & (state is IDLE or DONE). `bus_out` = MDR at all times.
- **Misalign flag:** `misalign` is cleared only by `rst`.

## Timing
- **Reset values:**
  - state = IDLE.
  - MAR = 0, MDR = 0, counter = 0.
  - `busy`, `done`, `bus_oe`, `misalign`, `ram_en`, `ram_we` and `ram_regce` are all 0.
  - `ram_addr` = 0 and `ram_din` = 0.
- **Reset mid-transaction:** the FSM returns to IDLE on the next edge. `ram_we` is never asserted after a reset edge, and no partial `done` is produced.
- **Read latency:** with a request sampled at edge E0:
  - RD occupies cycles 1..RD_LAT.
  - CAP is cycle RD_LAT+1.
  - `done` is high in cycle RD_LAT+2, with MDR already valid.
  - With RD_LAT=2, `done` comes 4 cycles after the request.
- **Write latency:** WR is cycle 1, the RAM writes at edge E1, and `done` is high in cycle 2.
- **Back-to-back:** the next request is accepted in the first IDLE cycle after DONE. The minimum spacing is RD_LAT+3 cycles for reads and 3 cycles for writes.
- **Address and data stability:** `ram_addr` and `ram_din` are stable for the whole transaction, because MAR and MDR are frozen while the FSM is outside IDLE.
- **Outputs:** all outputs are decoded from registered state only, with no input-to-output combinational path, except `bus_oe`, which is combinational from `mdr_bus_en`.
- **Address wrap:** MAR bits above ADDR_W+1 are ignored, so `ram_addr` wraps modulo 2^ADDR_W.

## Structure
- Add `typedef enum logic [2:0] {M_IDLE, M_RD, M_CAP, M_WR, M_DONE} memState;` to `mypack`, alongside `uState`.
- The counter width is $clog2(RD_LAT+1), computed locally.
- No sub-module: one FSM block, one datapath register block, and continuous assigns for the outputs.
- The core top instantiates `mem_bus_if` in place of its direct RAM hookup. The control unit supplies `mar_en`, `mdr_en`, `rd_req`, `wr_req` and `mdr_bus_en` from its enable vector, and waits on `done`.

## Test plan
- **Reset:** assert `rst` for 2 cycles with random inputs → every output is 0 and the state is IDLE.
- **Write then read:** `bus_in`=0x0000_0010 with `mar_en`; `bus_in`=0xDEAD_BEEF with `mdr_en`; `wr_req` → `ram_we` high for 1 cycle at `ram_addr`=4, and `done` at +2. Then `rd_req` → `ram_regce` high in cycle 2, `done` at +4, MDR = 0xDEAD_BEEF, and with `mdr_bus_en` `bus_oe`=1 and `bus_out`=0xDEAD_BEEF.
- **Misaligned request:** MAR=0x0000_0013 then `rd_req` → no `ram_en`, no `done`, and `misalign`=1 until reset.
- **Requests while busy:** `wr_req`, `rd_req` and `mar_en` pulsed during RD → ignored; MAR unchanged; exactly one `done`.
- **Reset mid-read:** `rst` in cycle 2 of RD → IDLE next cycle, no `done`, no `ram_we`.
- **Wrap and latency parameter:** MAR=0x0000_1004 with ADDR_W=10 → `ram_addr`=1. Re-run the read with RD_LAT=3 → `done` at +5.

Source files
------------

// File: rtl/mem_bus_if_pkg.sv
// Shared types for the memory bus interface.
// memState: the five states of the RAM transaction sequencer.
package mem_bus_if_pkg;

    typedef enum logic [2:0] {
        M_IDLE,
        M_RD,
        M_CAP,
        M_WR,
        M_DONE
    } memState;

endpackage : mem_bus_if_pkg

// File: rtl/mem_bus_if.sv
// Memory bus interface: MAR/MDR registers between the core databus and a
// synchronous block RAM, plus the FSM that sequences RAM strobes for a read
// or write and pulses done on completion.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bus_in            databus value; loads MAR (mar_en) / MDR (mdr_en)
//   rd_req, wr_req    start a read at MAR / write of MDR to MAR
//   mdr_bus_en        request MDR onto the databus
//   bus_out, bus_oe   MDR value and its drive enable
//   busy, done        transaction in progress / one-cycle completion pulse
//   misalign          sticky error: misaligned or conflicting request
//   ram_*             block RAM address, data, enable, write, output-reg CE
module mem_bus_if
    import mem_bus_if_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_en,
    input  logic              mdr_en,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic              mdr_bus_en,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              busy,
    output logic              done,
    output logic              misalign,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_en,
    output logic              ram_we,
    output logic              ram_regce,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int unsigned CNT_W = $clog2(RD_LAT + 1);
    localparam int unsigned MAR_W = ADDR_W + 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    memState          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             misalign_q, misalign_d;
    // Only the byte offset and word-address bits of MAR are kept; higher
    // bus bits would wrap anyway.
    logic [MAR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;

    // Next-state, read-latency counter and sticky error flag.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        misalign_d = misalign_q;
        unique case (state_q)
            M_IDLE: begin
                if (rd_req && wr_req) begin
                    misalign_d = 1'b1;
                end else if ((rd_req || wr_req) && (mar_q[1:0] != 2'b00)) begin
                    misalign_d = 1'b1;
                end else if (rd_req) begin
                    state_d = M_RD;
                    cnt_d   = '0;
                end else if (wr_req) begin
                    state_d = M_WR;
                end
            end
            M_RD: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = M_CAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            M_CAP:   state_d = M_DONE;
            M_WR:    state_d = M_DONE;
            M_DONE:  state_d = M_IDLE;
            default: state_d = M_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= M_IDLE;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
        end
    end

    // MAR/MDR are frozen outside IDLE so RAM address and data stay stable.
    always_comb begin
        mar_d = mar_q;
        mdr_d = mdr_q;
        if (state_q == M_IDLE) begin
            if (mar_en) mar_d = bus_in[MAR_W-1:0];
            if (mdr_en) mdr_d = bus_in;
        end else if (state_q == M_CAP) begin
            mdr_d = ram_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mar_q <= '0;
            mdr_q <= '0;
        end else begin
            mar_q <= mar_d;
            mdr_q <= mdr_d;
        end
    end

    // Strobes decoded from registered state only.
    assign busy      = (state_q == M_RD) || (state_q == M_CAP) || (state_q == M_WR);
    assign done      = (state_q == M_DONE);
    assign ram_we    = (state_q == M_WR);
    assign ram_en    = ((state_q == M_RD) && (cnt_q == '0)) || (state_q == M_WR);
    assign ram_regce = (state_q == M_RD) && (cnt_q == CNT_LAST);
    assign misalign  = misalign_q;
    assign ram_addr  = mar_q[MAR_W-1:2];
    assign ram_din   = mdr_q;
    assign bus_out   = mdr_q;

    // Held low while in reset so the bus is never driven from a stale state.
    assign bus_oe = mdr_bus_en && !rst && ((state_q == M_IDLE) || (state_q == M_DONE));

endmodule : mem_bus_if

// File: tb/tb_mem_bus_if.sv
// Bench for mem_bus_if: a behavioural model (transaction-level timing rules,
// word-array memory) predicts each transaction and pushes it to a queue; a
// monitor on the falling edge compares the DUT's strobes and data against it.
// A second instance with RD_LAT=3 checks the latency parameter.
module tb_mem_bus_if;

    localparam int RL = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (RD_LAT=2)
    logic        rst, mar_en, mdr_en, rd_req, wr_req, mdr_bus_en;
    logic [31:0] bus_in, bus_out, ram_din, ram_dout;
    logic        bus_oe, busy, done, misalign, ram_en, ram_we, ram_regce;
    logic [9:0]  ram_addr;

    mem_bus_if #(.ADDR_W(10), .DATA_W(32), .RD_LAT(2)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .mar_en(mar_en), .mdr_en(mdr_en),
        .rd_req(rd_req), .wr_req(wr_req), .mdr_bus_en(mdr_bus_en),
        .bus_out(bus_out), .bus_oe(bus_oe), .busy(busy), .done(done),
        .misalign(misalign), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_en(ram_en), .ram_we(ram_we), .ram_regce(ram_regce), .ram_dout(ram_dout)
    );

    // Second instance (RD_LAT=3)
    logic        b_rst, b_mar_en, b_mdr_en, b_rd_req, b_wr_req, b_mdr_bus_en;
    logic [31:0] b_bus_in, b_bus_out, b_ram_din, b_ram_dout;
    logic        b_bus_oe, b_busy, b_done, b_misalign, b_ram_en, b_ram_we, b_ram_regce;
    logic [9:0]  b_ram_addr;

    mem_bus_if #(.ADDR_W(10), .DATA_W(32), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(b_rst), .bus_in(b_bus_in), .mar_en(b_mar_en), .mdr_en(b_mdr_en),
        .rd_req(b_rd_req), .wr_req(b_wr_req), .mdr_bus_en(b_mdr_bus_en),
        .bus_out(b_bus_out), .bus_oe(b_bus_oe), .busy(b_busy), .done(b_done),
        .misalign(b_misalign), .ram_addr(b_ram_addr), .ram_din(b_ram_din),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_regce(b_ram_regce), .ram_dout(b_ram_dout)
    );

    // Block RAM models: address registered on enable, then output register.
    logic [31:0] ram_mem  [1024];
    logic [31:0] ram3_mem [1024];
    logic [31:0] ram_p0, ram3_p0, ram3_p1;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_din;
            else        ram_p0 <= ram_mem[ram_addr];
        end
        if (ram_regce) ram_dout <= ram_p0;
    end

    always @(posedge clk) begin
        if (b_ram_en) begin
            if (b_ram_we) ram3_mem[b_ram_addr] <= b_ram_din;
            else          ram3_p0 <= ram3_mem[b_ram_addr];
        end
        ram3_p1 <= ram3_p0;
        if (b_ram_regce) b_ram_dout <= ram3_p1;
    end

    // Checking bookkeeping
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model state
    typedef struct {
        bit          is_rd;
        logic [9:0]  addr;
        logic [31:0] data;
        int          done_cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_mem [1024];
    logic [11:0] m_mar;
    logic [31:0] m_mdr;
    bit          m_mis;
    int          free_cyc  = 0;
    int          busy_last = -1;

    // Model: at each edge decide what the interface accepts. A read sampled
    // at edge E0 completes RL+2 cycles later; a write 2 cycles later; the next
    // request is accepted RL+3 / 3 edges after E0.
    initial begin : model
        exp_t e;
        m_mar = '0;
        m_mdr = '0;
        m_mis = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                exp_q.delete();
                busy_last = -1;
                free_cyc  = 0;
                m_mar     = '0;
                m_mdr     = '0;
                m_mis     = 1'b0;
            end else if (cyc >= free_cyc) begin
                if (rd_req && wr_req) begin
                    m_mis = 1'b1;
                end else if ((rd_req || wr_req) && (m_mar[1:0] != 2'b00)) begin
                    m_mis = 1'b1;
                end else if (rd_req) begin
                    e.is_rd    = 1'b1;
                    e.addr     = m_mar[11:2];
                    e.data     = m_mem[m_mar[11:2]];
                    busy_last  = cyc + RL;
                    e.done_cyc = busy_last + 1;
                    free_cyc   = cyc + RL + 3;
                    m_mdr      = e.data;
                    exp_q.push_back(e);
                end else if (wr_req) begin
                    e.is_rd    = 1'b0;
                    e.addr     = m_mar[11:2];
                    e.data     = m_mdr;
                    m_mem[m_mar[11:2]] = m_mdr;
                    busy_last  = cyc;
                    e.done_cyc = cyc + 1;
                    free_cyc   = cyc + 3;
                    exp_q.push_back(e);
                end
                if (mar_en) m_mar = bus_in[11:0];
                if (mdr_en) m_mdr = bus_in;
            end
        end
    end

    // Monitor: compare every falling edge against the model's prediction.
    initial begin : monitor
        exp_t f;
        bit   have, eb, xd, xwe, xrc, xen;
        @(posedge clk);
        forever begin
            @(negedge clk);
            have = (exp_q.size() > 0);
            if (have) f = exp_q[0];
            eb  = (cyc <= busy_last);
            xd  = have && (f.done_cyc == cyc);
            xwe = have && !f.is_rd && (f.done_cyc - 1 == cyc);
            xrc = have && f.is_rd && (f.done_cyc - 2 == cyc);
            xen = xwe || (have && f.is_rd && (f.done_cyc - 1 - RL == cyc));
            chk("busy",      32'(busy),      32'(eb));
            chk("done",      32'(done),      32'(xd));
            chk("ram_en",    32'(ram_en),    32'(xen));
            chk("ram_we",    32'(ram_we),    32'(xwe));
            chk("ram_regce", 32'(ram_regce), 32'(xrc));
            chk("misalign",  32'(misalign),  32'(m_mis));
            chk("bus_oe",    32'(bus_oe),    32'(mdr_bus_en && !rst && !eb));
            chk("ram_addr",  32'(ram_addr),  32'(m_mar[11:2]));
            if (xen) chk("txn_addr", 32'(ram_addr), 32'(f.addr));
            if (xwe) chk("wr_data", ram_din, f.data);
            if (!eb) begin
                chk("bus_out", bus_out, m_mdr);
                chk("ram_din", ram_din, m_mdr);
            end
            if (xd) begin
                if (f.is_rd) chk("rd_data", bus_out, f.data);
                void'(exp_q.pop_front());
            end
        end
    end

    // Driver helpers: inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 1'b0; mar_en = 1'b0; mdr_en = 1'b0;
        rd_req = 1'b0; wr_req = 1'b0; mdr_bus_en = 1'b0;
    endtask

    task automatic load_mar(input logic [31:0] v);
        bus_in = v; mar_en = 1'b1; step(); mar_en = 1'b0;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        bus_in = v; mdr_en = 1'b1; step(); mdr_en = 1'b0;
    endtask

    initial begin : driver
        int lat;
        bit found;
        int r;

        for (int i = 0; i < 1024; i++) begin
            ram_mem[i]  = '0;
            ram3_mem[i] = '0;
            m_mem[i]    = '0;
        end
        clear_inputs();
        bus_in = '0;
        b_rst = 1'b1; b_mar_en = 1'b0; b_mdr_en = 1'b0;
        b_rd_req = 1'b0; b_wr_req = 1'b0; b_mdr_bus_en = 1'b0; b_bus_in = '0;

        // Reset with random inputs for two cycles
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus_in = $urandom; mar_en = 1'($urandom_range(0, 1)); mdr_en = 1'($urandom_range(0, 1));
            rd_req = 1'($urandom_range(0, 1)); wr_req = 1'($urandom_range(0, 1));
            mdr_bus_en = 1'($urandom_range(0, 1));
            step();
        end
        clear_inputs();

        // Write 0xDEADBEEF to byte address 0x10, then read it back
        load_mar(32'h0000_0010);
        load_mdr(32'hDEAD_BEEF);
        wr_req = 1'b1; step(); wr_req = 1'b0;
        @(negedge clk);
        chk("wr_we_cycle1", 32'(ram_we), 32'd1);
        chk("wr_addr_word4", 32'(ram_addr), 32'd4);
        @(negedge clk);
        chk("wr_done_plus2", 32'(done), 32'd1);
        @(posedge clk); #1;
        bus_in = 32'h1234_5678;
        rd_req = 1'b1; step(); rd_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rd_regce_cycle2", 32'(ram_regce), 32'd1);
        @(negedge clk);
        mdr_bus_en = 1'b1;
        @(negedge clk);
        chk("rd_done_plus4", 32'(done), 32'd1);
        chk("rd_bus_out", bus_out, 32'hDEAD_BEEF);
        chk("rd_bus_oe", 32'(bus_oe), 32'd1);
        @(posedge clk); #1;
        mdr_bus_en = 1'b0;

        // Address wrap: upper MAR bits are dropped
        load_mar(32'h0000_1004);
        @(negedge clk);
        chk("wrap_addr", 32'(ram_addr), 32'd1);
        @(posedge clk); #1;

        // Misaligned read: no transaction, sticky flag
        load_mar(32'h0000_0013);
        rd_req = 1'b1; step(); rd_req = 1'b0;
        repeat (5) step();
        chk("misalign_sticky", 32'(misalign), 32'd1);

        // Requests and loads during a read are ignored
        load_mar(32'h0000_0010);
        rd_req = 1'b1; step(); rd_req = 1'b0;
        rd_req = 1'b1; wr_req = 1'b1; mar_en = 1'b1; mdr_en = 1'b1; bus_in = 32'h0000_0044;
        step();
        clear_inputs();
        repeat (5) step();
        chk("busy_mar_frozen", 32'(ram_addr), 32'd4);

        // Reset in the second RD cycle
        rd_req = 1'b1; step(); rd_req = 1'b0;
        step();
        rst = 1'b1; step(); rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_read_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        repeat (6) step();

        // RD_LAT=3 instance: write then read, done expected 5 cycles after request
        repeat (2) step();
        b_rst = 1'b0;
        b_bus_in = 32'h0000_0020; b_mar_en = 1'b1; step(); b_mar_en = 1'b0;
        b_bus_in = 32'hCAFE_F00D; b_mdr_en = 1'b1; step(); b_mdr_en = 1'b0;
        b_bus_in = 32'h0;
        b_wr_req = 1'b1; step(); b_wr_req = 1'b0;
        repeat (3) step();
        b_rd_req = 1'b1; step(); b_rd_req = 1'b0;
        lat = 0; found = 1'b0;
        for (int k = 1; k <= 20 && !found; k++) begin
            @(negedge clk);
            if (b_done) begin
                found = 1'b1;
                lat   = k;
            end
        end
        chk("lat3_done_cycle", 32'(lat), 32'd5);
        chk("lat3_data", b_bus_out, 32'hCAFE_F00D);
        chk("lat3_addr", 32'(b_ram_addr), 32'd8);
        chk("lat3_misalign", 32'(b_misalign), 32'd0);
        chk("lat3_busy", 32'(b_busy), 32'd0);
        chk("lat3_bus_oe", 32'(b_bus_oe), 32'd0);
        @(posedge clk); #1;

        // Random traffic: loads and requests never share a cycle
        for (int n = 0; n < 3000; n++) begin
            clear_inputs();
            bus_in     = $urandom;
            mdr_bus_en = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 99));
            if (r < 15) begin
                mar_en = 1'b1;
                if ($urandom_range(0, 9) != 0) bus_in[1:0] = 2'b00;
            end else if (r < 30) begin
                mdr_en = 1'b1;
            end else if (r < 32) begin
                mar_en = 1'b1; mdr_en = 1'b1; bus_in[1:0] = 2'b00;
            end else if (r < 50) begin
                rd_req = 1'b1;
            end else if (r < 68) begin
                wr_req = 1'b1;
            end else if (r < 69) begin
                rd_req = 1'b1; wr_req = 1'b1;
            end else if (r < 71) begin
                rst = 1'b1;
            end
            step();
        end
        clear_inputs();
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_bus_if
